// File: rtl/bus_src_arbiter.sv
// -----------------------------------------------------------------------------
// bus_src_arbiter
//
// Round-robin owner selection for the shared 16-source, 8-bit bus multiplexer.
// At most one requester holds the bus at a time. The owner's index drives the
// mux select. Ownership ends when the owner drops its request, or when it has
// held the bus for MAX_HOLD consecutive cycles. After every ownership there is
// one dead bus cycle before the next grant.
//
// Parameters
//   MAX_HOLD     maximum consecutive grant cycles per ownership (0 = no limit)
//
// Ports
//   i_clk        system clock, all state changes on the rising edge
//   i_rst        synchronous active-high reset
//   i_req        request vector, bit i = source i wants the bus
//   o_sel        mux select, index of the current or most recent owner
//   o_gnt        one-hot grant, all-zero when the bus is idle
//   o_bus_valid  high while a grant is active
//   o_hold_cnt   0-based count of cycles the current owner has held the bus
//                (saturates at 255)
// -----------------------------------------------------------------------------
module bus_src_arbiter #(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_req,
   output logic [3:0]  o_sel,
   output logic [15:0] o_gnt,
   output logic        o_bus_valid,
   output logic [7:0]  o_hold_cnt
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // A limit of zero disables the timeout entirely.
   localparam logic       HOLD_LIMITED = (MAX_HOLD != 0);
   // This is the last hold_cnt value an owner may reach. The edge that
   // samples this value is the release edge.
   localparam logic [7:0] HOLD_LAST    = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

   // Round-robin scan starts at last+1 and wraps 15 -> 0, so the previous owner
   // is visited last. The loop walks from the farthest candidate to the nearest
   // one. This way the nearest set bit is written last and wins.
   // Returns {found, index}.
   function automatic logic [4:0] rr_pick(input logic [15:0] req, input logic [3:0] last);
      logic [4:0] res;
      logic [3:0] idx;
      res = 5'd0;
      for (int i = 16; i >= 1; i--) begin
         idx = last + 4'(i);
         res = req[idx] ? {1'b1, idx} : res;
      end
      return res;
   endfunction

   // Converts a 4-bit index to a 16-bit one-hot grant.
   function automatic logic [15:0] to_onehot(input logic [3:0] idx);
      return 16'd1 << idx;
   endfunction

   state_t      r_state;
   logic [3:0]  r_sel;
   logic [15:0] r_gnt;
   logic        r_bus_valid;
   logic [7:0]  r_hold_cnt;
   logic [3:0]  r_last_owner;

   logic        w_pick_valid;
   logic [3:0]  w_pick_idx;
   logic [15:0] w_pick_onehot;
   logic        w_owner_dropped;
   logic        w_timeout;
   logic        w_release;

   // Next-owner selection and release conditions, all from registered state plus i_req.
   always_comb begin
      w_pick_valid    = 1'b0;
      w_pick_idx      = 4'd0;
      w_pick_onehot   = 16'd0;
      w_owner_dropped = 1'b0;
      w_timeout       = 1'b0;
      w_release       = 1'b0;

      {w_pick_valid, w_pick_idx} = rr_pick(i_req, r_last_owner);
      w_pick_onehot   = to_onehot(w_pick_idx);
      w_owner_dropped = ~i_req[r_sel];
      if (HOLD_LIMITED) begin
         w_timeout = (r_hold_cnt == HOLD_LAST);
      end else begin
         w_timeout = 1'b0;
      end
      w_release = w_owner_dropped | w_timeout;
   end

   // Arbitration FSM. All outputs are registered here.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_sel        <= 4'd0;
         r_gnt        <= 16'd0;
         r_bus_valid  <= 1'b0;
         r_hold_cnt   <= 8'd0;
         // After reset the scan starts at index 0, so source 0 has top priority.
         r_last_owner <= 4'd15;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pick_valid) begin
                  r_state      <= ST_BUSY;
                  r_sel        <= w_pick_idx;
                  r_gnt        <= w_pick_onehot;
                  r_bus_valid  <= 1'b1;
                  r_hold_cnt   <= 8'd0;
                  r_last_owner <= w_pick_idx;
               end else begin
                  // Idle bus: sel keeps pointing at the most recent owner.
                  r_state      <= ST_IDLE;
                  r_gnt        <= 16'd0;
                  r_bus_valid  <= 1'b0;
                  r_hold_cnt   <= 8'd0;
               end
            end
            ST_BUSY: begin
               if (w_release) begin
                  // The bus is dead for one cycle. sel is left unchanged.
                  r_state     <= ST_IDLE;
                  r_gnt       <= 16'd0;
                  r_bus_valid <= 1'b0;
                  r_hold_cnt  <= 8'd0;
               end else if (r_hold_cnt != 8'hFF) begin
                  r_hold_cnt  <= r_hold_cnt + 8'd1;
               end else begin
                  r_hold_cnt  <= r_hold_cnt;
               end
            end
            default: begin
               // Unreachable encoding: return to a safe idle bus.
               r_state     <= ST_IDLE;
               r_gnt       <= 16'd0;
               r_bus_valid <= 1'b0;
               r_hold_cnt  <= 8'd0;
            end
         endcase
      end
   end

   assign o_sel       = r_sel;
   assign o_gnt       = r_gnt;
   assign o_bus_valid = r_bus_valid;
   assign o_hold_cnt  = r_hold_cnt;

endmodule

// File: tb/tb_bus_src_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_src_arbiter
//
// Directed bench for bus_src_arbiter. Three instances share the clock and
// reset, and each has a different hold limit (4, 3, 0). Every expected value
// below is hand-computed from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_bus_src_arbiter;

   logic        clk;
   logic        rst;
   logic [15:0] req4, req3, req0;
   logic [3:0]  sel4, sel3, sel0;
   logic [15:0] gnt4, gnt3, gnt0;
   logic        bv4, bv3, bv0;
   logic [7:0]  hc4, hc3, hc0;

   int checks;
   int failures;

   bus_src_arbiter #(.MAX_HOLD(4)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_req(req4),
      .o_sel(sel4), .o_gnt(gnt4), .o_bus_valid(bv4), .o_hold_cnt(hc4)
   );

   bus_src_arbiter #(.MAX_HOLD(3)) dut3 (
      .i_clk(clk), .i_rst(rst), .i_req(req3),
      .o_sel(sel3), .o_gnt(gnt3), .o_bus_valid(bv3), .o_hold_cnt(hc3)
   );

   bus_src_arbiter #(.MAX_HOLD(0)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_req(req0),
      .o_sel(sel0), .o_gnt(gnt0), .o_bus_valid(bv0), .o_hold_cnt(hc0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Checks all four outputs of the selected instance (4, 3 or 0).
   task automatic chk_out(input string tag, input int which, input logic [15:0] eg,
                          input logic [3:0] es, input logic ev, input logic [7:0] eh);
      logic [15:0] g;
      logic [3:0]  s;
      logic        v;
      logic [7:0]  h;
      if (which == 4) begin
         g = gnt4; s = sel4; v = bv4; h = hc4;
      end else if (which == 3) begin
         g = gnt3; s = sel3; v = bv3; h = hc3;
      end else begin
         g = gnt0; s = sel0; v = bv0; h = hc0;
      end
      chk({tag, ".gnt"}, g, eg);
      chk({tag, ".sel"}, 16'(s), 16'(es));
      chk({tag, ".valid"}, 16'(v), 16'(ev));
      chk({tag, ".hold"}, 16'(h), 16'(eh));
   endtask

   // Advances one clock, samples 1 time unit after the edge, and checks that gnt[sel] matches bus_valid.
   task automatic step();
      @(posedge clk);
      #1;
      chk("inv4", 16'(gnt4[sel4]), 16'(bv4));
      chk("inv3", 16'(gnt3[sel3]), 16'(bv3));
      chk("inv0", 16'(gnt0[sel0]), 16'(bv0));
   endtask

   initial begin
      logic [15:0] exp_g;
      logic [3:0]  exp_s;
      logic [7:0]  exp_h;
      checks   = 0;
      failures = 0;
      rst  = 1'b1;
      req4 = 16'h0000;
      req3 = 16'h0000;
      req0 = 16'h0000;

      // ---- Reset priority ------------------------------------------------
      req4 = 16'h8001;
      step();
      step();
      chk_out("rst_hold4", 4, 16'h0000, 4'd0, 1'b0, 8'd0);
      chk_out("rst_hold3", 3, 16'h0000, 4'd0, 1'b0, 8'd0);
      chk_out("rst_hold0", 0, 16'h0000, 4'd0, 1'b0, 8'd0);
      rst = 1'b0;
      step();
      chk_out("rst_prio", 4, 16'h0001, 4'd0, 1'b1, 8'd0);

      // ---- Round-robin wrap, MAX_HOLD=4 ----------------------------------
      rst = 1'b1;
      req4 = 16'hFFFF;
      step();
      chk_out("rr_rst", 4, 16'h0000, 4'd0, 1'b0, 8'd0);
      rst = 1'b0;
      for (int k = 0; k < 17; k++) begin
         exp_s = 4'(k);
         exp_g = 16'd1 << exp_s;
         for (int c = 0; c < 4; c++) begin
            step();
            chk_out($sformatf("rr_own%0d_c%0d", k, c), 4, exp_g, exp_s, 1'b1, 8'(c));
         end
         step();
         chk_out($sformatf("rr_idle%0d", k), 4, 16'h0000, exp_s, 1'b0, 8'd0);
      end

      // ---- Voluntary release and handover to source 9 ---------------------
      rst = 1'b1;
      step();
      rst = 1'b0;
      req4 = 16'h0020;
      step();
      chk_out("vol_g0", 4, 16'h0020, 4'd5, 1'b1, 8'd0);
      step();
      chk_out("vol_g1", 4, 16'h0020, 4'd5, 1'b1, 8'd1);
      req4 = 16'h0200;
      step();
      chk_out("vol_dead", 4, 16'h0000, 4'd5, 1'b0, 8'd0);
      step();
      chk_out("vol_new0", 4, 16'h0200, 4'd9, 1'b1, 8'd0);
      step();
      chk_out("vol_new1", 4, 16'h0200, 4'd9, 1'b1, 8'd1);
      req4 = 16'h0000;

      // ---- Sole requester timeout, MAX_HOLD=3 ------------------------------
      rst = 1'b1;
      step();
      rst = 1'b0;
      req3 = 16'h0400;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            step();
            chk_out($sformatf("sole_r%0d_c%0d", r, c), 3, 16'h0400, 4'd10, 1'b1, 8'(c));
         end
         step();
         chk_out($sformatf("sole_idle%0d", r), 3, 16'h0000, 4'd10, 1'b0, 8'd0);
      end
      req3 = 16'h0000;

      // ---- No hold limit, MAX_HOLD=0 -------------------------------------
      rst = 1'b1;
      step();
      rst = 1'b0;
      req0 = 16'h0003;
      for (int c = 0; c < 300; c++) begin
         exp_h = (c < 255) ? 8'(c) : 8'd255;
         step();
         chk_out($sformatf("nolim_c%0d", c), 0, 16'h0001, 4'd0, 1'b1, exp_h);
      end
      req0 = 16'h0000;

      // ---- Reset mid-ownership --------------------------------------------
      rst = 1'b1;
      step();
      rst = 1'b0;
      req4 = 16'h0080;
      step();
      chk_out("mid_c0", 4, 16'h0080, 4'd7, 1'b1, 8'd0);
      step();
      chk_out("mid_c1", 4, 16'h0080, 4'd7, 1'b1, 8'd1);
      step();
      chk_out("mid_c2", 4, 16'h0080, 4'd7, 1'b1, 8'd2);
      rst = 1'b1;
      step();
      chk_out("mid_rst", 4, 16'h0000, 4'd0, 1'b0, 8'd0);
      rst = 1'b0;
      step();
      chk_out("mid_regrant", 4, 16'h0080, 4'd7, 1'b1, 8'd0);

      // ---- Idle with no requests keeps sel ---------------------------------
      req4 = 16'h0000;
      step();
      chk_out("idle_rel", 4, 16'h0000, 4'd7, 1'b0, 8'd0);
      step();
      chk_out("idle_keep", 4, 16'h0000, 4'd7, 1'b0, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bus_src_arbiter.md
# bus_src_arbiter

Round-robin arbiter that shares the 16-source, 8-bit bus multiplexer among up to 16 requesting units. Each cycle it grants at most one requester, drives the multiplexer select with that requester's index, and forces release after a configurable hold limit so no source can starve the others. It sits between the requesting units (registers, RAM, ALU, I/O) and the 4-bit select input of the bus mux.

## Interface
- MAX_HOLD, default 4: maximum consecutive grant cycles per ownership; 0 disables the limit.
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  16  request vector; bit i high = source i wants the bus.
- sel  output  4  mux select; index of current or last owner.
- gnt  output  16  one-hot grant; all-zero when idle.
- bus_valid  output  1  high while a grant is active (gnt nonzero).
- hold_cnt  output  8  cycles the current owner has held the bus, 0-based.

## Operation
- States: IDLE, BUSY.
- Reset: state IDLE, sel=0, gnt=0, bus_valid=0, hold_cnt=0, internal last_owner=15, so index 0 has top priority after reset.
- IDLE: if req is nonzero, pick the first set bit scanning upward from last_owner+1 (mod 16, wrapping 15→0). At the next edge: gnt=one-hot(winner), sel=winner, last_owner=winner, hold_cnt=0, bus_valid=1, state BUSY. If req==0, remain IDLE; sel keeps its value.
- BUSY, release condition = req[sel]==0 OR (MAX_HOLD≠0 AND hold_cnt==MAX_HOLD-1).
  - Release: next edge gnt=0, bus_valid=0, hold_cnt=0, state IDLE; sel unchanged.
  - Otherwise: hold_cnt increments (saturates at 255), gnt and sel unchanged.
- Requests from non-owners during BUSY are ignored until IDLE; no preemption other than timeout.
- Timeout-released owner still requesting is treated as any other requester: lowest priority in the next scan because last_owner equals it.
- Sole requester with timeout: re-granted after one IDLE cycle.
- gnt is always one-hot or zero; gnt[sel]==bus_valid at all times.
- rst overrides everything, including mid-ownership; the owner loses the bus at that edge.

## Timing
- Grant latency: req sampled at edge N in IDLE → gnt/sel valid after edge N (visible cycle N+1).
- Release latency: owner drops req before edge M → gnt=0 after edge M; next grant earliest after edge M+1 (one dead bus cycle, turnaround).
- Timeout: owner granted after edge G holds cycles G+1..G+MAX_HOLD; gnt falls after edge G+MAX_HOLD.
- Outputs are registered; no combinational path from req to any output.

## Test plan
- Reset priority: assert rst, then req=16'h8001 → after one edge gnt=16'h0001, sel=0, bus_valid=1; during reset all outputs 0 and sel=0.
- Round-robin wrap: req=16'hFFFF held, MAX_HOLD=4 → grant order 0,1,2,…,15,0; each owner holds exactly 4 cycles, then 1 idle cycle (gnt=0).
- Voluntary release: grant source 5 (req=16'h0020), drop req after 2 cycles with req[9] high → gnt=0 for one cycle, then gnt=16'h0200, sel=9, hold_cnt restarts at 0.
- Sole requester timeout: MAX_HOLD=3, req=16'h0400 constant → pattern gnt=0x0400 ×3, 0 ×1, repeating; sel stays 10 throughout.
- No limit: MAX_HOLD=0, req=16'h0003 constant → source 0 holds indefinitely (check 300 cycles, hold_cnt saturates at 255, source 1 never granted).
- Reset mid-ownership: source 7 owning, hold_cnt=2, assert rst one cycle with req=16'h0080 → outputs clear that edge; after release of rst, source 7 re-granted (last_owner reset to 15, 7 is first set bit from 0).
